// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared trigger-level encodings and threshold helper for the UART FIFO
package uart_pkg;

    typedef enum logic [1:0] {
        TRIG_ONE     = 2'b00,
        TRIG_QUARTER = 2'b01,
        TRIG_HALF    = 2'b10,
        TRIG_NEAR    = 2'b11
    } trig_level_e;

    localparam int TRIG_ONE_LEVEL   = 1;
    localparam int TRIG_NEAR_MARGIN = 2;

    // Threshold in entries for a given level code and FIFO depth.
    function automatic int trig_threshold(input logic [1:0] lvl, input int depth);
        int thr;
        thr = TRIG_ONE_LEVEL;
        case (trig_level_e'(lvl))
            TRIG_ONE:     thr = TRIG_ONE_LEVEL;
            TRIG_QUARTER: thr = depth / 4;
            TRIG_HALF:    thr = depth / 2;
            TRIG_NEAR:    thr = depth - TRIG_NEAR_MARGIN;
            default:      thr = TRIG_ONE_LEVEL;
        endcase
        return thr;
    endfunction

endpackage

// File: rtl/uart_raminfr.sv
// rtl/uart_raminfr.sv - dual-port FIFO storage, synchronous write, asynchronous read
module uart_raminfr #(
    parameter int ADDR_WIDTH = 4,
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 16
) (
    input  logic                  clk,
    input  logic                  we,
    input  logic [ADDR_WIDTH-1:0] waddr,
    input  logic [DATA_WIDTH-1:0] wdata,
    input  logic [ADDR_WIDTH-1:0] raddr,
    output logic [DATA_WIDTH-1:0] rdata
);

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[waddr] <= wdata;
        end
    end

    assign rdata = mem_q[raddr];

endmodule

// File: rtl/uart_fifo_ctrl.sv
// rtl/uart_fifo_ctrl.sv - UART FIFO controller; UART_FIFO_TRIGGER_EN adds trig_level/trig
module uart_fifo_ctrl
    import uart_pkg::*;
#(
    parameter int ADDR_WIDTH = 4,
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 16
) (
    input  logic                  clk,
    input  logic                  nreset,
    input  logic                  push,
    input  logic [DATA_WIDTH-1:0] data_in,
    input  logic                  pop,
    output logic [DATA_WIDTH-1:0] data_out,
    input  logic                  fifo_clear,
    input  logic                  overrun_clr,
`ifdef UART_FIFO_TRIGGER_EN
    input  logic [1:0]            trig_level,
    output logic                  trig,
`endif
    output logic [ADDR_WIDTH:0]   count,
    output logic                  empty,
    output logic                  full,
    output logic                  overrun
);

    localparam logic [ADDR_WIDTH:0] DEPTH_C = (ADDR_WIDTH + 1)'(DEPTH);

    logic [ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
    logic [ADDR_WIDTH:0]   count_q, count_d;
    logic                  overrun_q, overrun_d;

    logic push_ok, pop_ok, drop, ram_we;

    assign empty = (count_q == '0);
    assign full  = (count_q == DEPTH_C);

    // A full FIFO can still take a push when the head leaves in the same cycle.
    assign pop_ok  = pop && !empty;
    assign push_ok = push && (!full || pop_ok);
    assign drop    = push && !push_ok && !fifo_clear;
    assign ram_we  = push_ok && !fifo_clear;

    always_comb begin
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        count_d   = count_q;
        overrun_d = overrun_q;

        if (fifo_clear) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push_ok) begin
                wr_ptr_d = wr_ptr_q + 1'b1;
            end
            if (pop_ok) begin
                rd_ptr_d = rd_ptr_q + 1'b1;
            end
            case ({push_ok, pop_ok})
                2'b10:   count_d = count_q + 1'b1;
                2'b01:   count_d = count_q - 1'b1;
                default: count_d = count_q;
            endcase
        end

        // A drop wins over a coincident clear request.
        if (drop) begin
            overrun_d = 1'b1;
        end else if (overrun_clr) begin
            overrun_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
            overrun_q <= 1'b0;
        end else begin
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            count_q   <= count_d;
            overrun_q <= overrun_d;
        end
    end

    assign count   = count_q;
    assign overrun = overrun_q;

`ifdef UART_FIFO_TRIGGER_EN
    assign trig = (int'(count_q) >= trig_threshold(trig_level, DEPTH));
`endif

    uart_raminfr #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (DEPTH)
    ) u_ram (
        .clk   (clk),
        .we    (ram_we),
        .waddr (wr_ptr_q),
        .wdata (data_in),
        .raddr (rd_ptr_q),
        .rdata (data_out)
    );

endmodule

// File: tb/tb_uart_fifo_ctrl.sv
// tb/tb_uart_fifo_ctrl.sv - self-checking bench for uart_fifo_ctrl with a queue reference model
module tb_uart_fifo_ctrl;

    localparam int AW = 4;
    localparam int DW = 8;
    localparam int DEPTH = 16;

    logic          clk = 1'b0;
    logic          nreset;
    logic          push, pop, fifo_clear, overrun_clr;
    logic [DW-1:0] data_in;
    logic [DW-1:0] data_out;
    logic [AW:0]   count;
    logic          empty, full, overrun;
`ifdef UART_FIFO_TRIGGER_EN
    logic [1:0]    trig_level;
    logic          trig;
`endif

    int total = 0;
    int bad = 0;

    logic [7:0] mq[$];
    logic       m_ovr;

    always #5 clk = ~clk;

    uart_fifo_ctrl #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .DEPTH(DEPTH)) dut (
        .clk         (clk),
        .nreset      (nreset),
        .push        (push),
        .data_in     (data_in),
        .pop         (pop),
        .data_out    (data_out),
        .fifo_clear  (fifo_clear),
        .overrun_clr (overrun_clr),
`ifdef UART_FIFO_TRIGGER_EN
        .trig_level  (trig_level),
        .trig        (trig),
`endif
        .count       (count),
        .empty       (empty),
        .full        (full),
        .overrun     (overrun)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    function automatic int model_thr(input logic [1:0] lvl);
        case (lvl)
            2'b00:   return 1;
            2'b01:   return DEPTH / 4;
            2'b10:   return DEPTH / 2;
            default: return DEPTH - 2;
        endcase
    endfunction

    task automatic model_update(input logic p, input logic o, input logic c,
                                input logic oc, input logic [7:0] d);
        bit pop_ok, push_ok, dropped;
        dropped = 1'b0;
        if (c) begin
            mq.delete();
        end else begin
            pop_ok  = o && (mq.size() > 0);
            push_ok = p && ((mq.size() < DEPTH) || pop_ok);
            dropped = p && !push_ok;
            if (pop_ok) void'(mq.pop_front());
            if (push_ok) mq.push_back(d);
        end
        if (dropped) m_ovr = 1'b1;
        else if (oc) m_ovr = 1'b0;
    endtask

    task automatic model_check(input string tag);
        chk({tag, ".count"}, 32'(count), 32'(mq.size()));
        chk({tag, ".empty"}, 32'(empty), 32'(mq.size() == 0));
        chk({tag, ".full"}, 32'(full), 32'(mq.size() == DEPTH));
        chk({tag, ".overrun"}, 32'(overrun), 32'(m_ovr));
        if (mq.size() > 0) chk({tag, ".data_out"}, 32'(data_out), 32'(mq[0]));
`ifdef UART_FIFO_TRIGGER_EN
        chk({tag, ".trig"}, 32'(trig), 32'(int'(mq.size()) >= model_thr(trig_level)));
`endif
    endtask

    task automatic step(input logic p, input logic o, input logic c,
                        input logic oc, input logic [7:0] d, input string tag);
        push = p; pop = o; fifo_clear = c; overrun_clr = oc; data_in = d;
        @(posedge clk);
        model_update(p, o, c, oc, d);
        #1;
        push = 1'b0; pop = 1'b0; fifo_clear = 1'b0; overrun_clr = 1'b0;
        model_check(tag);
    endtask

    typedef struct {
        logic       p, o, c, oc;
        logic [7:0] d;
        int         e_count;
        logic       e_empty, e_full, e_ovr;
        logic [7:0] e_dout;
    } vec_t;

    vec_t vecs[6];
    int bias;

    initial begin
        vecs[0] = '{1, 0, 0, 0, 8'hA5, 1, 0, 0, 0, 8'hA5};
        vecs[1] = '{0, 1, 0, 0, 8'h00, 0, 1, 0, 0, 8'h00};
        vecs[2] = '{0, 1, 0, 0, 8'h00, 0, 1, 0, 0, 8'h00};
        vecs[3] = '{1, 1, 0, 0, 8'h3C, 1, 0, 0, 0, 8'h3C};
        vecs[4] = '{1, 0, 0, 0, 8'h5A, 2, 0, 0, 0, 8'h3C};
        vecs[5] = '{0, 1, 0, 0, 8'h00, 1, 0, 0, 0, 8'h5A};

        nreset = 1'b0; push = 0; pop = 0; fifo_clear = 0; overrun_clr = 0; data_in = '0;
`ifdef UART_FIFO_TRIGGER_EN
        trig_level = 2'b00;
`endif
        mq.delete(); m_ovr = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst.count", 32'(count), 0);
        chk("rst.empty", 32'(empty), 1);
        chk("rst.full", 32'(full), 0);
        chk("rst.overrun", 32'(overrun), 0);
`ifdef UART_FIFO_TRIGGER_EN
        chk("rst.trig", 32'(trig), 0);
`endif
        nreset = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 6; i++) begin
            step(vecs[i].p, vecs[i].o, vecs[i].c, vecs[i].oc, vecs[i].d, $sformatf("vec%0d", i));
            chk($sformatf("vec%0d.count", i), 32'(count), 32'(vecs[i].e_count));
            chk($sformatf("vec%0d.empty", i), 32'(empty), 32'(vecs[i].e_empty));
            chk($sformatf("vec%0d.full", i), 32'(full), 32'(vecs[i].e_full));
            chk($sformatf("vec%0d.overrun", i), 32'(overrun), 32'(vecs[i].e_ovr));
            if (!vecs[i].e_empty)
                chk($sformatf("vec%0d.dout", i), 32'(data_out), 32'(vecs[i].e_dout));
        end
        step(0, 1, 0, 0, 0, "drain");

        // Fill, drop on full, drain in order
        for (int i = 0; i < 16; i++) step(1, 0, 0, 0, 8'(i), "fill");
        chk("fill.full", 32'(full), 1);
        step(1, 0, 0, 0, 8'h55, "drop");
        chk("drop.overrun", 32'(overrun), 1);
        chk("drop.count", 32'(count), 16);
        for (int i = 0; i < 16; i++) begin
            chk("order.dout", 32'(data_out), 32'(i));
            step(0, 1, 0, 0, 0, "order");
        end
        chk("order.empty", 32'(empty), 1);

        // Full with simultaneous push and pop
        step(0, 0, 0, 1, 0, "oclr");
        for (int i = 0; i < 16; i++) step(1, 0, 0, 0, 8'(8'h10 + i), "fill2");
        step(1, 1, 0, 0, 8'h77, "fullpp");
        chk("fullpp.count", 32'(count), 16);
        chk("fullpp.overrun", 32'(overrun), 0);
        for (int i = 1; i < 16; i++) begin
            chk("wrap.dout", 32'(data_out), 32'(8'h10 + i));
            step(0, 1, 0, 0, 0, "wrap");
        end
        chk("wrap.last", 32'(data_out), 32'h77);
        step(0, 1, 0, 0, 0, "wrap_end");

        // Empty push+pop, then clear with push keeps overrun
        step(1, 1, 0, 0, 8'h3C, "emptypp");
        chk("emptypp.count", 32'(count), 1);
        chk("emptypp.dout", 32'(data_out), 32'h3C);
        for (int i = 0; i < 15; i++) step(1, 0, 0, 0, 8'(i), "fill3");
        step(1, 0, 0, 0, 8'hEE, "drop3");
        for (int i = 0; i < 11; i++) step(0, 1, 0, 0, 0, "pop11");
        chk("pre_clr.count", 32'(count), 5);
        step(1, 0, 1, 0, 8'h99, "clear");
        chk("clear.count", 32'(count), 0);
        chk("clear.empty", 32'(empty), 1);
        chk("clear.overrun", 32'(overrun), 1);

`ifdef UART_FIFO_TRIGGER_EN
        trig_level = 2'b01;
        for (int i = 0; i < 3; i++) step(1, 0, 0, 0, 8'(i), "trq");
        chk("trig_q3", 32'(trig), 0);
        step(1, 0, 0, 0, 8'h04, "trq4");
        chk("trig_q4", 32'(trig), 1);
        trig_level = 2'b11;
        for (int i = 0; i < 10; i++) step(1, 0, 0, 0, 8'(i), "trn");
        chk("trig_n14", 32'(trig), 1);
        step(0, 1, 0, 0, 0, "trn13");
        chk("trig_n13", 32'(trig), 0);
`endif

        // Drop coincident with overrun_clr, then async reset mid-burst
        step(0, 0, 1, 1, 0, "clr2");
        for (int i = 0; i < 16; i++) step(1, 0, 0, 0, 8'(i), "fill4");
        step(1, 0, 0, 1, 8'hAA, "drop_oclr");
        chk("drop_oclr.overrun", 32'(overrun), 1);
        step(0, 0, 0, 1, 0, "oclr_only");
        chk("oclr_only.overrun", 32'(overrun), 0);
        for (int i = 0; i < 5; i++) step(0, 1, 0, 0, 0, "burst");
        push = 1'b1; data_in = 8'h12;
        #2;
        nreset = 1'b0;
        #1;
        chk("async_rst.count", 32'(count), 0);
        chk("async_rst.empty", 32'(empty), 1);
        push = 1'b0;
        mq.delete(); m_ovr = 1'b0;
        @(negedge clk);
        nreset = 1'b1;
        @(posedge clk);
        #1;
        model_check("post_rst");

        // Randomized traffic against the queue model
        bias = 70;
        for (int n = 0; n < 3000; n++) begin
            if (n % 200 == 0) bias = (bias == 70) ? 30 : 70;
`ifdef UART_FIFO_TRIGGER_EN
            if (n % 50 == 0) trig_level = 2'($urandom_range(0, 3));
`endif
            step($urandom_range(0, 99) < bias,
                 $urandom_range(0, 99) < (100 - bias),
                 $urandom_range(0, 99) < 2,
                 $urandom_range(0, 99) < 5,
                 8'($urandom), "rand");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
